// File: rtl/nes_pkg.sv
// Shared NES pad definitions: button bit positions, frame length and
// counter width, used by the pad emulator and the console-side reader.
package nes_pkg;

   // Bit position of each button in the 8-bit pad word (A is shifted first)
   typedef enum logic [2:0] {
      BTN_A      = 3'd0,
      BTN_B      = 3'd1,
      BTN_SELECT = 3'd2,
      BTN_START  = 3'd3,
      BTN_UP     = 3'd4,
      BTN_DOWN   = 3'd5,
      BTN_LEFT   = 3'd6,
      BTN_RIGHT  = 3'd7
   } nes_btn_e;

   localparam int NES_BITS  = 8;
   localparam int NES_CNT_W = 4;

   // Shift counter step: counts up to NES_BITS and sticks there
   function automatic logic [NES_CNT_W-1:0] nes_sat_inc(
      input logic [NES_CNT_W-1:0] c
   );
      if (c == NES_CNT_W'(NES_BITS)) begin
         return c;
      end
      return c + NES_CNT_W'(1);
   endfunction

endpackage

// File: rtl/nes_sync_edge.sv
// Two-flop synchronizer for an asynchronous console line plus a third
// flop for rising-edge detection.
// Ports: clk, rst (sync, active-high), d_in (async in),
//        level (synchronized level), rise (one-cycle rise pulse).
module nes_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic d_in,
   output logic level,
   output logic rise
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic s3_q, s3_d;

   always_comb begin
      s1_d = d_in;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign level = s2_q;
   assign rise  = s2_q & ~s3_q;

endmodule

// File: rtl/nes_pad_emulator.sv
// Device-side NES controller: a CD4021-style parallel-in/serial-out
// register clocked from clk, fed by oversampled console latch/clock.
// Ports: clk, rst (sync, active-high), buttons[7:0] (pressed=1),
//        turbo_mask[7:0], latch_in, c_clk_in (async console lines),
//        data_out (active-low wire level), bit_count[3:0], frame_done.
// Optional: define NES_PAD_TURBO_EN to enable per-button turbo.
module nes_pad_emulator
   import nes_pkg::*;
#(
   parameter logic        FILL_BIT  = 1'b0,
   parameter int unsigned TURBO_DIV = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] buttons,
   input  logic [7:0] turbo_mask,
   input  logic       latch_in,
   input  logic       c_clk_in,
   output logic       data_out,
   output logic [3:0] bit_count,
   output logic       frame_done
);

   logic latch_lvl;
   logic latch_rise;
   logic clk_lvl;
   logic clk_rise;

   nes_sync_edge u_latch_sync (
      .clk   (clk),
      .rst   (rst),
      .d_in  (latch_in),
      .level (latch_lvl),
      .rise  (latch_rise)
   );

   nes_sync_edge u_clk_sync (
      .clk   (clk),
      .rst   (rst),
      .d_in  (c_clk_in),
      .level (clk_lvl),
      .rise  (clk_rise)
   );

   logic [NES_BITS-1:0] buttons_eff;

`ifdef NES_PAD_TURBO_EN
   logic [7:0] edge_q, edge_d;
   logic       phase_q, phase_d;

   // Phase flips once every TURBO_DIV latch rises
   always_comb begin
      edge_d  = edge_q;
      phase_d = phase_q;
      if (latch_rise) begin
         if (edge_q + 8'd1 == 8'(TURBO_DIV)) begin
            edge_d  = 8'd0;
            phase_d = ~phase_q;
         end else begin
            edge_d = edge_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         edge_q  <= 8'd0;
         phase_q <= 1'b1;
      end else begin
         edge_q  <= edge_d;
         phase_q <= phase_d;
      end
   end

   assign buttons_eff = buttons & (~turbo_mask | {NES_BITS{phase_q}});

   logic unused_turbo;
   assign unused_turbo = clk_lvl;
`else
   assign buttons_eff = buttons;

   logic unused_turbo;
   assign unused_turbo = ^{turbo_mask, latch_rise, clk_lvl,
                           TURBO_DIV[7:0]};
`endif

   logic [NES_BITS-1:0]  shreg_q, shreg_d;
   logic [NES_CNT_W-1:0] cnt_q, cnt_d;
   logic                 done_q, done_d;

   // Latch has priority: a rise seen while latched is dropped
   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (latch_lvl) begin
         shreg_d = ~buttons_eff;
         cnt_d   = '0;
      end else if (clk_rise) begin
         shreg_d = {FILL_BIT, shreg_q[NES_BITS-1:1]};
         cnt_d   = nes_sat_inc(cnt_q);
         done_d  = (cnt_q == NES_CNT_W'(NES_BITS - 1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q <= '1;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign data_out   = shreg_q[0];
   assign bit_count  = cnt_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_nes_pad_emulator.sv
// Testbench for nes_pad_emulator: console-side stimulus against a
// frame-level model of the pad (wire bits = ~pressed, then fill).
module tb_nes_pad_emulator;

   localparam logic FILL = 1'b0;
   localparam int   DIV  = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] buttons;
   logic [7:0] turbo_mask;
   logic       latch_in;
   logic       c_clk_in;
   logic       data_out;
   logic [3:0] bit_count;
   logic       frame_done;

   int n_checks = 0;
   int n_fail   = 0;
   int latches  = 0;

   always #5 clk = ~clk;

   nes_pad_emulator #(
      .FILL_BIT  (FILL),
      .TURBO_DIV (DIV)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .buttons    (buttons),
      .turbo_mask (turbo_mask),
      .latch_in   (latch_in),
      .c_clk_in   (c_clk_in),
      .data_out   (data_out),
      .bit_count  (bit_count),
      .frame_done (frame_done)
   );

   // Effective pressed set after n latches since reset
   function automatic logic [7:0] eff_model(
      input logic [7:0] b,
      input logic [7:0] m,
      input int         n
   );
      logic       ph;
      logic [7:0] tm;
      ph = ((n / DIV) % 2) == 0;
      tm = m;
`ifndef NES_PAD_TURBO_EN
      tm = 8'h00;
`endif
      return b & (~tm | {8{ph}});
   endfunction

   task automatic latch_pulse(input int n);
      @(posedge clk);
      #1 latch_in = 1'b1;
      repeat (n) @(posedge clk);
      #1 latch_in = 1'b0;
      latches++;
      repeat (4) @(posedge clk);
      #1;
   endtask

   // One console clock pulse; reports frame_done pulses and when
   task automatic clk_pulse(
      input  int hi,
      input  int lo,
      output int dn,
      output int dat
   );
      dn  = 0;
      dat = -1;
      @(posedge clk);
      #1 c_clk_in = 1'b1;
      for (int i = 0; i < hi; i++) begin
         @(negedge clk);
         if (frame_done === 1'b1) begin
            dn++;
            dat = i;
         end
         @(posedge clk);
      end
      #1 c_clk_in = 1'b0;
      for (int i = 0; i < lo; i++) begin
         @(negedge clk);
         if (frame_done === 1'b1) dn++;
         @(posedge clk);
      end
      #1;
   endtask

   task automatic run_frame(
      input string      nm,
      input logic [7:0] b,
      input logic [7:0] m,
      input int         np,
      input int         hi,
      input int         lo
   );
      logic [7:0] e;
      logic       expd;
      int         dn, dat, expc;
      buttons    = b;
      turbo_mask = m;
      latch_pulse(12);
      e = ~eff_model(b, m, latches);
      n_checks++;
      if (bit_count !== 4'd0) begin
         n_fail++;
         $display("FAIL %s load bit_count got %0d want 0", nm, bit_count);
      end
      for (int k = 0; k < np; k++) begin
         expd = (k < 8) ? e[k] : FILL;
         n_checks++;
         if (data_out !== expd) begin
            n_fail++;
            $display("FAIL %s bit%0d data_out got %b want %b",
                     nm, k, data_out, expd);
         end
         clk_pulse(hi, lo, dn, dat);
         expc = (k + 1 > 8) ? 8 : k + 1;
         n_checks++;
         if (bit_count !== 4'(expc)) begin
            n_fail++;
            $display("FAIL %s shift%0d bit_count got %0d want %0d",
                     nm, k, bit_count, expc);
         end
         n_checks++;
         if (dn !== ((k == 7) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s shift%0d frame_done pulses got %0d want %0d",
                     nm, k, dn, (k == 7) ? 1 : 0);
         end
         if (k == 7) begin
            n_checks++;
            if (dat !== 3) begin
               n_fail++;
               $display("FAIL %s frame_done delay got %0d want 3", nm, dat);
            end
         end
      end
      expd = (np < 8) ? e[np] : FILL;
      n_checks++;
      if (data_out !== expd) begin
         n_fail++;
         $display("FAIL %s tail data_out got %b want %b", nm, data_out, expd);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      latches = 0;
   endtask

   task automatic test_reset();
      buttons    = 8'h00;
      turbo_mask = 8'h00;
      latch_in   = 1'b0;
      c_clk_in   = 1'b0;
      do_reset();
      repeat (5) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (data_out !== 1'b1) begin
         n_fail++;
         $display("FAIL reset data_out got %b want 1", data_out);
      end
      n_checks++;
      if (bit_count !== 4'd0) begin
         n_fail++;
         $display("FAIL reset bit_count got %0d want 0", bit_count);
      end
      n_checks++;
      if (frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset frame_done got %b want 0", frame_done);
      end
   endtask

   task automatic test_frame();
      run_frame("frame_a_sel", 8'h05, 8'h00, 10, 8, 8);
   endtask

   task automatic test_relatch();
      int dn, dat;
      buttons    = 8'h05;
      turbo_mask = 8'h00;
      latch_pulse(12);
      repeat (3) clk_pulse(8, 8, dn, dat);
      n_checks++;
      if (bit_count !== 4'd3) begin
         n_fail++;
         $display("FAIL relatch pre bit_count got %0d want 3", bit_count);
      end
      run_frame("relatch", 8'h80, 8'h00, 8, 8, 8);
   endtask

   task automatic test_simultaneous();
      logic [7:0] b, e;
      int         dn, dat;
      b          = 8'($urandom);
      buttons    = b;
      turbo_mask = 8'h00;
      @(posedge clk);
      #1 latch_in = 1'b1;
      c_clk_in = 1'b1;
      repeat (8) @(posedge clk);
      #1 latch_in = 1'b0;
      latches++;
      repeat (5) @(posedge clk);
      #1 c_clk_in = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      e = ~eff_model(b, 8'h00, latches);
      n_checks++;
      if (bit_count !== 4'd0) begin
         n_fail++;
         $display("FAIL simul bit_count got %0d want 0", bit_count);
      end
      n_checks++;
      if (data_out !== e[0]) begin
         n_fail++;
         $display("FAIL simul first bit got %b want %b", data_out, e[0]);
      end
      clk_pulse(6, 6, dn, dat);
      n_checks++;
      if (data_out !== e[1]) begin
         n_fail++;
         $display("FAIL simul second bit got %b want %b", data_out, e[1]);
      end
   endtask

   task automatic test_pending_rise();
      logic [7:0] b, e;
      b          = 8'($urandom);
      buttons    = b;
      turbo_mask = 8'h00;
      @(posedge clk);
      #1 latch_in = 1'b1;
      repeat (10) @(posedge clk);
      #1 latch_in = 1'b0;
      c_clk_in = 1'b1;
      latches++;
      repeat (6) @(posedge clk);
      #1 c_clk_in = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      e = ~eff_model(b, 8'h00, latches);
      n_checks++;
      if (bit_count !== 4'd1) begin
         n_fail++;
         $display("FAIL pending bit_count got %0d want 1", bit_count);
      end
      n_checks++;
      if (data_out !== e[1]) begin
         n_fail++;
         $display("FAIL pending data_out got %b want %b", data_out, e[1]);
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 6; f++) begin
         run_frame("random", 8'($urandom), 8'($urandom),
                   $urandom_range(11, 1), $urandom_range(10, 4),
                   $urandom_range(10, 4));
      end
   endtask

   task automatic test_turbo();
      logic [7:0] tbl, e;
      int         dn, dat;
`ifdef NES_PAD_TURBO_EN
      tbl = 8'h66;
`else
      tbl = 8'h00;
`endif
      do_reset();
      buttons    = 8'h01;
      turbo_mask = 8'h01;
      for (int f = 0; f < 8; f++) begin
         latch_pulse(12);
         e = ~eff_model(8'h01, 8'h01, latches);
         n_checks++;
         if (data_out !== tbl[f]) begin
            n_fail++;
            $display("FAIL turbo frame%0d A got %b want %b",
                     f, data_out, tbl[f]);
         end
         n_checks++;
         if (data_out !== e[0]) begin
            n_fail++;
            $display("FAIL turbo_model frame%0d A got %b want %b",
                     f, data_out, e[0]);
         end
         repeat (8) clk_pulse(4, 4, dn, dat);
      end
   endtask

   task automatic test_reset_midframe();
      int dn, dat;
      buttons    = 8'h3C;
      turbo_mask = 8'h00;
      latch_pulse(12);
      repeat (3) clk_pulse(6, 6, dn, dat);
      @(posedge clk);
      #1 rst = 1'b1;
      latch_in = 1'b1;
      c_clk_in = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (data_out !== 1'b1 || bit_count !== 4'd0 || frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst state got d=%b c=%0d f=%b want d=1 c=0 f=0",
                  data_out, bit_count, frame_done);
      end
      rst      = 1'b0;
      latch_in = 1'b0;
      c_clk_in = 1'b0;
      latches  = 0;
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (data_out !== 1'b1 || bit_count !== 4'd0) begin
         n_fail++;
         $display("FAIL midrst idle got d=%b c=%0d want d=1 c=0",
                  data_out, bit_count);
      end
      run_frame("after_rst", 8'($urandom), 8'($urandom), 8, 5, 5);
   endtask

   initial begin
      test_reset();
      test_frame();
      test_relatch();
      test_simultaneous();
      test_pending_rise();
      test_random();
      test_turbo();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
